// File: rtl/clk_enable_gen.sv
// clk_enable_gen: master-clock enable strobes for the game core.
// NUM_CH divider channels with a shadow-register reload handshake, and a
// non-overlapping phi_1/phi_2 generator with halt stretching and a cpu_en
// strobe. Nothing here creates a clock; everything is an enable on clk_96MHz.
module clk_enable_gen #(
    parameter int                        NUM_CH     = 4,
    parameter int                        DIV_W      = 12,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT   = {NUM_CH{DIV_W'(8)}},
    parameter int                        PHI_PERIOD = 64,
    parameter int                        P1_LEN     = 32,
    parameter int                        GAP_LEN    = 1
) (
    input  logic                      clk_96MHz,
    input  logic                      reset_n,
    input  logic                      run,
    input  logic                      div_load,
    input  logic [NUM_CH*DIV_W-1:0]   div_value,
    output logic                      div_busy,
    output logic                      div_ack,
    output logic [NUM_CH-1:0]         ce,
    input  logic                      halt,
    output logic                      phi_1,
    output logic                      phi_2,
    output logic                      cpu_en,
    output logic                      halted
);

    localparam int PC_W = (PHI_PERIOD > 2) ? $clog2(PHI_PERIOD) : 1;

    // Phase-counter landmarks within one phi period.
    localparam logic [PC_W-1:0] PC_P1_LAST   = PC_W'(P1_LEN - 1);
    localparam logic [PC_W-1:0] PC_G12_LAST  = PC_W'(P1_LEN + GAP_LEN - 1);
    localparam logic [PC_W-1:0] PC_P2_LAST   = PC_W'(PHI_PERIOD - GAP_LEN - 1);
    localparam logic [PC_W-1:0] PC_G21_FIRST = PC_W'(PHI_PERIOD - GAP_LEN);
    localparam logic [PC_W-1:0] PC_LAST      = PC_W'(PHI_PERIOD - 1);

    // The phase sequence needs room for both gaps and a non-empty phi_2.
    if (!((P1_LEN + 2 * GAP_LEN) < PHI_PERIOD) || (GAP_LEN < 1) || (P1_LEN < 1)) begin : g_bad_phase_timing
        $error("clk_enable_gen: require P1_LEN + 2*GAP_LEN < PHI_PERIOD with P1_LEN, GAP_LEN >= 1");
    end

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] apply;
    logic              load_accept;
    logic              all_done;
    logic              busy_q;
    logic              ack_q;

    // A request is only taken while no reload is outstanding.
    assign load_accept = div_load && !busy_q;
    // The reload completes on the edge where the last pending channel applies.
    assign all_done    = busy_q && ((pend & ~apply) == '0);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] shadow_q, shadow_d;
        logic             pend_q, pend_d;
        logic [DIV_W-1:0] eff;

        // A divisor of zero behaves as one: strobe on every run cycle.
        assign eff       = (div_q == '0) ? DIV_W'(1) : div_q;
        assign wrap[gi]  = run && (cnt_q == (eff - DIV_W'(1)));
        assign apply[gi] = wrap[gi] && pend_q;
        assign pend[gi]  = pend_q;
        assign ce[gi]    = reset_n && wrap[gi];

        // Count, wrap, and swap in the shadow divisor only at a period boundary.
        always_comb begin
            cnt_d    = cnt_q;
            div_d    = div_q;
            shadow_d = shadow_q;
            pend_d   = pend_q;
            if (run) begin
                cnt_d = wrap[gi] ? '0 : (cnt_q + DIV_W'(1));
            end
            if (apply[gi]) begin
                div_d  = shadow_q;
                pend_d = 1'b0;
            end
            if (load_accept) begin
                shadow_d = div_value[gi*DIV_W +: DIV_W];
                pend_d   = 1'b1;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk_96MHz or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= '0;
                div_q    <= DIV_INIT[gi*DIV_W +: DIV_W];
                shadow_q <= '0;
                pend_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                div_q    <= div_d;
                shadow_q <= shadow_d;
                pend_q   <= pend_d;
            end
        end
    end

    // Reload handshake: busy from acceptance until every channel has applied.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= all_done;
            if (all_done) begin
                busy_q <= 1'b0;
            end else if (load_accept) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign div_busy = busy_q;
    assign div_ack  = ack_q;

    // ------------------------------------------------------------------
    // Two-phase generator
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_G12,
        S_P2,
        S_G21,
        S_HOLD
    } phi_state_t;

    phi_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    // Next state and phase count; nothing moves while run is low.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (run) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_P1;
                    pc_d    = '0;
                end
                S_P1: begin
                    pc_d = pc_q + PC_W'(1);
                    if (pc_q == PC_P1_LAST) state_d = S_G12;
                end
                S_G12: begin
                    pc_d = pc_q + PC_W'(1);
                    if (pc_q == PC_G12_LAST) state_d = S_P2;
                end
                S_P2: begin
                    pc_d = pc_q + PC_W'(1);
                    if (pc_q == PC_P2_LAST) state_d = S_G21;
                end
                S_G21: begin
                    if (pc_q == PC_LAST) begin
                        pc_d    = '0;
                        state_d = halt ? S_HOLD : S_P1;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                S_HOLD: begin
                    // The releasing HOLD cycle stands in for pc=0 of the new P1.
                    pc_d = '0;
                    if (!halt) begin
                        state_d = S_P1;
                        pc_d    = PC_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end
            endcase
        end
    end

    // Phase state and counter registers.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Phase levels follow the state, so they freeze with it when run is low.
    assign phi_1  = (state_q == S_P1) || (state_q == S_HOLD);
    assign phi_2  = (state_q == S_P2);
    assign halted = (state_q == S_HOLD);
    assign cpu_en = reset_n && run && (state_q == S_G21) && (pc_q == PC_G21_FIRST);

endmodule
